// File: rtl/ccip_c0_rd_arbiter.sv
// ccip_c0_rd_arbiter
//
// Shares the single CCI-P c0 (read request) Tx channel among NUM_REQ AFU-internal
// requesters with a round-robin arbiter, tags each request's mdata with the requester
// ID in its top ID_W bits, and routes c0 read responses back to the owning requester
// by decoding those same bits.
//
// Optional feature (compile-time macro CCIP_C0_ARB_CREDIT_EN):
//   per-requester outstanding-read counters; a requester is only eligible for a grant
//   while its counter is below MAX_OUTSTANDING. Without the macro every requester is
//   always eligible and no counters exist.
//
// Ports:
//   vl_clk_LPdomain_16ui        clock
//   ffs_LP16ui_afu_SoftReset_n  synchronous active-low reset
//   req_valid   [NUM_REQ]          per-requester request pending
//   req_addr    [NUM_REQ*ADDR_W]   request address, requester i at slice i
//   req_mdata   [NUM_REQ*MDATA_W]  request mdata, top ID_W bits ignored
//   req_grant   [NUM_REQ]          one-hot accept strobe (combinational)
//   c0_almfull                     c0 Tx almost-full; blocks all grants
//   tx_c0_valid/addr/mdata         registered c0 read request
//   rx_c0_rdvalid/mdata/data       c0 read response from the FIU
//   rsp_valid   [NUM_REQ]          one-hot registered response strobe
//   rsp_mdata                      response mdata with the ID bits cleared
//   rsp_data    [512]              response data
//   err_bad_id                     sticky: a response carried an ID >= NUM_REQ

module ccip_c0_rd_arbiter #(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned ID_W            = 3,
    parameter int unsigned ADDR_W          = 42,
    parameter int unsigned MDATA_W         = 16,
    parameter int unsigned MAX_OUTSTANDING = 32
) (
    input  logic                       vl_clk_LPdomain_16ui,
    input  logic                       ffs_LP16ui_afu_SoftReset_n,

    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*MDATA_W-1:0] req_mdata,
    output logic [NUM_REQ-1:0]         req_grant,

    input  logic                       c0_almfull,
    output logic                       tx_c0_valid,
    output logic [ADDR_W-1:0]          tx_c0_addr,
    output logic [MDATA_W-1:0]         tx_c0_mdata,

    input  logic                       rx_c0_rdvalid,
    input  logic [MDATA_W-1:0]         rx_c0_mdata,
    input  logic [511:0]               rx_c0_data,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [MDATA_W-1:0]         rsp_mdata,
    output logic [511:0]               rsp_data,
    output logic                       err_bad_id
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned LOW_W = MDATA_W - ID_W;

    // Elaboration-time guard against configurations the tagging scheme cannot support.
    if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << ID_W) < NUM_REQ || ID_W >= MDATA_W ||
        MAX_OUTSTANDING < 1) begin : g_bad_cfg
        $error("ccip_c0_rd_arbiter: unsupported parameter combination");
    end

    logic clk;
    logic rst_n;
    assign clk   = vl_clk_LPdomain_16ui;
    assign rst_n = ffs_LP16ui_afu_SoftReset_n;

    // ------------------------------------------------------------------------
    // Response decode (needed by the credit counters as well as the rsp path)
    // ------------------------------------------------------------------------
    logic [ID_W-1:0]    rx_id;
    logic               rx_id_ok;
    logic               rx_route;
    logic [NUM_REQ-1:0] rx_onehot;

    always_comb begin
        rx_id     = rx_c0_mdata[MDATA_W-1 -: ID_W];
        rx_id_ok  = (32'(rx_id) < NUM_REQ);
        rx_route  = rx_c0_rdvalid && rx_id_ok;
        rx_onehot = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rx_onehot[i] = rx_route && (32'(rx_id) == i);
        end
    end

    // ------------------------------------------------------------------------
    // Eligibility
    // ------------------------------------------------------------------------
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;

`ifdef CCIP_C0_ARB_CREDIT_EN
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [CNT_W-1:0] cnt_q [NUM_REQ];

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            eligible[i] = (32'(cnt_q[i]) < MAX_OUTSTANDING);
        end
    end

    // Grant and routed response in the same cycle cancel out. A response with no
    // outstanding credit (e.g. one that straddled a reset) leaves the counter at 0.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!rst_n) begin
                cnt_q[i] <= '0;
            end else if (grant[i] && !rx_onehot[i]) begin
                cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end else if (!grant[i] && rx_onehot[i] && (cnt_q[i] != '0)) begin
                cnt_q[i] <= cnt_q[i] - CNT_W'(1);
            end
        end
    end
`else
    assign eligible = '1;
`endif

    // ------------------------------------------------------------------------
    // Round-robin arbitration
    // ------------------------------------------------------------------------
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [PTR_W-1:0]   cand;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_any;
    logic [ADDR_W-1:0]  sel_addr;
    logic [LOW_W-1:0]   sel_mdata_low;

    // Search starts one past the last winner and wraps, so the last winner has the
    // lowest priority this cycle.
    always_comb begin
        cand          = '0;
        grant_idx     = '0;
        grant_any     = 1'b0;
        grant         = '0;
        sel_addr      = '0;
        sel_mdata_low = '0;
        if (rst_n && !c0_almfull) begin
            for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                cand = PTR_W'((32'(rr_ptr_q) + k) % NUM_REQ);
                if (!grant_any && req_valid[cand] && eligible[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
            if (grant_any) begin
                grant[grant_idx] = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr      = req_addr[i*ADDR_W +: ADDR_W];
                sel_mdata_low = req_mdata[i*MDATA_W +: LOW_W];
            end
        end
    end

    assign req_grant = grant;

    // ------------------------------------------------------------------------
    // Request issue register: one cycle after the grant
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q    <= PTR_W'(NUM_REQ - 1);
            tx_c0_valid <= 1'b0;
            tx_c0_addr  <= '0;
            tx_c0_mdata <= '0;
        end else begin
            tx_c0_valid <= grant_any;
            if (grant_any) begin
                rr_ptr_q    <= grant_idx;
                tx_c0_addr  <= sel_addr;
                tx_c0_mdata <= {ID_W'(grant_idx), sel_mdata_low};
            end
        end
    end

    // ------------------------------------------------------------------------
    // Response routing register: stateless, the ID travels in the mdata
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid  <= '0;
            rsp_mdata  <= '0;
            rsp_data   <= '0;
            err_bad_id <= 1'b0;
        end else begin
            rsp_valid <= rx_onehot;
            if (rx_route) begin
                rsp_mdata <= {{ID_W{1'b0}}, rx_c0_mdata[LOW_W-1:0]};
                rsp_data  <= rx_c0_data;
            end
            if (rx_c0_rdvalid && !rx_id_ok) begin
                err_bad_id <= 1'b1;
            end
        end
    end

    // The requesters' own ID bits are overwritten by the tag.
    logic unused_req_mdata;
    assign unused_req_mdata = ^req_mdata;

endmodule

// File: tb/tb_ccip_c0_rd_arbiter.sv
module tb_ccip_c0_rd_arbiter;

    localparam int N   = 4;
    localparam int AW  = 42;
    localparam int MW  = 16;
    localparam int IW  = 3;
    localparam int MAX = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*MW-1:0] req_mdata;
    logic [N-1:0]   req_grant;
    logic           c0_almfull;
    logic           tx_c0_valid;
    logic [AW-1:0]  tx_c0_addr;
    logic [MW-1:0]  tx_c0_mdata;
    logic           rx_c0_rdvalid;
    logic [MW-1:0]  rx_c0_mdata;
    logic [511:0]   rx_c0_data;
    logic [N-1:0]   rsp_valid;
    logic [MW-1:0]  rsp_mdata;
    logic [511:0]   rsp_data;
    logic           err_bad_id;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ccip_c0_rd_arbiter #(
        .NUM_REQ        (N),
        .ID_W           (IW),
        .ADDR_W         (AW),
        .MDATA_W        (MW),
        .MAX_OUTSTANDING(MAX)
    ) dut (
        .vl_clk_LPdomain_16ui      (clk),
        .ffs_LP16ui_afu_SoftReset_n(rst_n),
        .req_valid                 (req_valid),
        .req_addr                  (req_addr),
        .req_mdata                 (req_mdata),
        .req_grant                 (req_grant),
        .c0_almfull                (c0_almfull),
        .tx_c0_valid               (tx_c0_valid),
        .tx_c0_addr                (tx_c0_addr),
        .tx_c0_mdata               (tx_c0_mdata),
        .rx_c0_rdvalid             (rx_c0_rdvalid),
        .rx_c0_mdata               (rx_c0_mdata),
        .rx_c0_data                (rx_c0_data),
        .rsp_valid                 (rsp_valid),
        .rsp_mdata                 (rsp_mdata),
        .rsp_data                  (rsp_data),
        .err_bad_id                (err_bad_id)
    );

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] fixed_addr(input int i);
        return 42'h3_0000_0000 + AW'(i * 64 + 5);
    endfunction

    function automatic logic [MW-1:0] fixed_md(input int i);
        return 16'hE000 | MW'(i * 17 + 1);
    endfunction

    function automatic logic [MW-1:0] tag(input int i, input logic [MW-1:0] m);
        return {IW'(i), m[MW-IW-1:0]};
    endfunction

    function automatic logic [511:0] data_of(input int r);
        return {16{32'hA500_0000 + 32'(r)}};
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        return (g < 0) ? '0 : N'(1 << g);
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid     = '0;
        c0_almfull    = 1'b0;
        rx_c0_rdvalid = 1'b0;
        rx_c0_mdata   = '0;
        rx_c0_data    = '0;
    endtask

    task automatic set_fixed_fields();
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = fixed_addr(i);
            req_mdata[i*MW +: MW] = fixed_md(i);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------------------------------------------------------------
    // Directed table
    // ---------------------------------------------------------------------
    typedef struct {
        logic [N-1:0]  req;
        logic          alm;
        logic          rdv;
        logic [MW-1:0] rxm;
        int            exp_g;   // expected grant index this cycle, -1 none
        int            exp_tx;  // requester expected on tx this cycle, -1 none
        logic [N-1:0]  exp_rv;
        logic [MW-1:0] exp_rm;
        logic          exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [N-1:0] req, input logic alm, input logic rdv,
                                input logic [MW-1:0] rxm, input int g, input int tx,
                                input logic [N-1:0] rv, input logic [MW-1:0] rm,
                                input logic err);
        vec_t v;
        v.req = req; v.alm = alm; v.rdv = rdv; v.rxm = rxm;
        v.exp_g = g; v.exp_tx = tx; v.exp_rv = rv; v.exp_rm = rm; v.exp_err = err;
        vecs.push_back(v);
    endfunction

    task automatic run_table();
        for (int r = 0; r < vecs.size(); r++) begin
            tick();
            chk($sformatf("tbl%0d tx_valid", r), 512'(tx_c0_valid), 512'(vecs[r].exp_tx >= 0));
            if (vecs[r].exp_tx >= 0) begin
                chk($sformatf("tbl%0d tx_addr", r), 512'(tx_c0_addr),
                    512'(fixed_addr(vecs[r].exp_tx)));
                chk($sformatf("tbl%0d tx_mdata", r), 512'(tx_c0_mdata),
                    512'(tag(vecs[r].exp_tx, fixed_md(vecs[r].exp_tx))));
            end
            chk($sformatf("tbl%0d rsp_valid", r), 512'(rsp_valid), 512'(vecs[r].exp_rv));
            if (vecs[r].exp_rv != '0) begin
                chk($sformatf("tbl%0d rsp_mdata", r), 512'(rsp_mdata), 512'(vecs[r].exp_rm));
                chk($sformatf("tbl%0d rsp_data", r), rsp_data, data_of(r - 1));
            end
            chk($sformatf("tbl%0d err_bad_id", r), 512'(err_bad_id), 512'(vecs[r].exp_err));
            req_valid     = vecs[r].req;
            c0_almfull    = vecs[r].alm;
            rx_c0_rdvalid = vecs[r].rdv;
            rx_c0_mdata   = vecs[r].rxm;
            rx_c0_data    = data_of(r);
            #1;
            chk($sformatf("tbl%0d grant", r), 512'(req_grant), 512'(onehot(vecs[r].exp_g)));
        end
    endtask

    // ---------------------------------------------------------------------
    // Randomised run against a transaction-level model
    // ---------------------------------------------------------------------
    task automatic run_random(input int cycles);
        int            rr;
        int            cnt [N];
        logic          m_tx_v;
        logic [AW-1:0] m_tx_a;
        logic [MW-1:0] m_tx_m;
        logic [N-1:0]  m_rv;
        logic [MW-1:0] m_rm;
        logic [511:0]  m_rd;
        logic          m_err;
        int            g;
        int            id;
        logic [MW-1:0] md;

        rr = N - 1;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        m_tx_v = 1'b0; m_rv = '0; m_err = 1'b0;
        m_tx_a = '0; m_tx_m = '0; m_rm = '0; m_rd = '0;

        for (int c = 0; c < cycles; c++) begin
            tick();
            chk("rnd tx_valid", 512'(tx_c0_valid), 512'(m_tx_v));
            if (m_tx_v) begin
                chk("rnd tx_addr", 512'(tx_c0_addr), 512'(m_tx_a));
                chk("rnd tx_mdata", 512'(tx_c0_mdata), 512'(m_tx_m));
            end
            chk("rnd rsp_valid", 512'(rsp_valid), 512'(m_rv));
            if (m_rv != '0) begin
                chk("rnd rsp_mdata", 512'(rsp_mdata), 512'(m_rm));
                chk("rnd rsp_data", rsp_data, m_rd);
            end
            chk("rnd err_bad_id", 512'(err_bad_id), 512'(m_err));

            req_valid  = N'($urandom);
            c0_almfull = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) begin
                req_addr[i*AW +: AW]  = AW'({$urandom, $urandom});
                req_mdata[i*MW +: MW] = MW'($urandom);
            end
            rx_c0_rdvalid = $urandom_range(0, 1) == 1;
            id = ($urandom_range(0, 29) == 0) ? $urandom_range(N, 7) : $urandom_range(0, N - 1);
            rx_c0_mdata = {IW'(id), (MW - IW)'($urandom)};
            for (int w = 0; w < 16; w++) rx_c0_data[w*32 +: 32] = $urandom;
            #1;

            // Expected grant: first eligible requester after the last winner.
            g = -1;
            if (!c0_almfull) begin
                for (int k = 1; k <= N; k++) begin
                    int idx;
                    idx = (rr + k) % N;
`ifdef CCIP_C0_ARB_CREDIT_EN
                    if (g < 0 && req_valid[idx] && cnt[idx] < MAX) g = idx;
`else
                    if (g < 0 && req_valid[idx]) g = idx;
`endif
                end
            end
            chk("rnd grant", 512'(req_grant), 512'(onehot(g)));

            m_tx_v = (g >= 0);
            if (g >= 0) begin
                rr     = g;
                m_tx_a = req_addr[g*AW +: AW];
                md     = req_mdata[g*MW +: MW];
                m_tx_m = tag(g, md);
                cnt[g] = cnt[g] + 1;
            end
            m_rv = '0;
            if (rx_c0_rdvalid) begin
                if (id < N) begin
                    m_rv = onehot(id);
                    m_rm = rx_c0_mdata & 16'h1FFF;
                    m_rd = rx_c0_data;
                    if (cnt[id] > 0) cnt[id] = cnt[id] - 1;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    // ---------------------------------------------------------------------
    // Main sequence
    // ---------------------------------------------------------------------
    initial begin
        rst_n = 1'b0;
        idle_inputs();
        req_addr  = '0;
        req_mdata = '0;
        set_fixed_fields();
        do_reset();

        // Reset state
        chk("reset tx_valid", 512'(tx_c0_valid), 512'(0));
        chk("reset tx_addr", 512'(tx_c0_addr), 512'(0));
        chk("reset tx_mdata", 512'(tx_c0_mdata), 512'(0));
        chk("reset rsp_valid", 512'(rsp_valid), 512'(0));
        chk("reset rsp_mdata", 512'(rsp_mdata), 512'(0));
        chk("reset rsp_data", rsp_data, 512'(0));
        chk("reset err", 512'(err_bad_id), 512'(0));

`ifndef CCIP_C0_ARB_CREDIT_EN
        //   req      alm  rdv  rxm       g   tx  rv       rm        err
        add(4'b1111, 0, 0, 16'h0000,  0, -1, 4'b0000, 16'h0000, 0);
        add(4'b1111, 0, 0, 16'h0000,  1,  0, 4'b0000, 16'h0000, 0);
        add(4'b1111, 0, 0, 16'h0000,  2,  1, 4'b0000, 16'h0000, 0);
        add(4'b1111, 0, 0, 16'h0000,  3,  2, 4'b0000, 16'h0000, 0);
        add(4'b1111, 0, 0, 16'h0000,  0,  3, 4'b0000, 16'h0000, 0);
        add(4'b1010, 0, 0, 16'h0000,  1,  0, 4'b0000, 16'h0000, 0);
        add(4'b1010, 0, 0, 16'h0000,  3,  1, 4'b0000, 16'h0000, 0);
        add(4'b1010, 0, 0, 16'h0000,  1,  3, 4'b0000, 16'h0000, 0);
        add(4'b1010, 0, 0, 16'h0000,  3,  1, 4'b0000, 16'h0000, 0);
        add(4'b1111, 1, 0, 16'h0000, -1,  3, 4'b0000, 16'h0000, 0);
        add(4'b1111, 1, 0, 16'h0000, -1, -1, 4'b0000, 16'h0000, 0);
        add(4'b1111, 1, 0, 16'h0000, -1, -1, 4'b0000, 16'h0000, 0);
        add(4'b1111, 1, 0, 16'h0000, -1, -1, 4'b0000, 16'h0000, 0);
        add(4'b1111, 1, 0, 16'h0000, -1, -1, 4'b0000, 16'h0000, 0);
        add(4'b1111, 0, 0, 16'h0000,  0, -1, 4'b0000, 16'h0000, 0);
        add(4'b0000, 0, 0, 16'h0000, -1,  0, 4'b0000, 16'h0000, 0);
        add(4'b0000, 0, 1, 16'h4ABC, -1, -1, 4'b0000, 16'h0000, 0);
        add(4'b0000, 0, 1, 16'hE000, -1, -1, 4'b0100, 16'h0ABC, 0);
        add(4'b0000, 0, 0, 16'h0000, -1, -1, 4'b0000, 16'h0000, 1);
        add(4'b0010, 0, 1, 16'h2000,  1, -1, 4'b0000, 16'h0000, 1);
        add(4'b0000, 0, 1, 16'h7FFF, -1,  1, 4'b0010, 16'h0000, 1);
        add(4'b0000, 0, 0, 16'h0000, -1, -1, 4'b1000, 16'h1FFF, 1);
        add(4'b0000, 0, 0, 16'h0000, -1, -1, 4'b0000, 16'h0000, 1);
        run_table();
`endif

        // Reset in the middle of a burst, then a stale response for requester 1.
        set_fixed_fields();
        do_reset();
        req_valid = 4'b1111;
        tick();
        tick();
        tick();
        chk("midrst tx_valid before", 512'(tx_c0_valid), 512'(1));
        rst_n = 1'b0;
        #1;
        chk("midrst grant in reset", 512'(req_grant), 512'(0));
        tick();
        chk("midrst tx_valid cleared", 512'(tx_c0_valid), 512'(0));
        chk("midrst rsp_valid cleared", 512'(rsp_valid), 512'(0));
        rst_n         = 1'b1;
        rx_c0_rdvalid = 1'b1;
        rx_c0_mdata   = 16'h2123;
        rx_c0_data    = data_of(77);
        #1;
        chk("midrst first grant", 512'(req_grant), 512'(4'b0001));
        tick();
        chk("midrst tx id0", 512'(tx_c0_mdata), 512'(tag(0, fixed_md(0))));
        chk("midrst stale rsp_valid", 512'(rsp_valid), 512'(4'b0010));
        chk("midrst stale rsp_mdata", 512'(rsp_mdata), 512'(16'h0123));
        chk("midrst stale rsp_data", rsp_data, data_of(77));
        rx_c0_rdvalid = 1'b0;
        req_valid     = 4'b0010;
        #1;
        chk("midrst req1 grant a", 512'(req_grant), 512'(4'b0010));
        tick();
        #1;
        chk("midrst req1 grant b", 512'(req_grant), 512'(4'b0010));
        tick();
        #1;
`ifdef CCIP_C0_ARB_CREDIT_EN
        chk("midrst req1 credit limit", 512'(req_grant), 512'(4'b0000));
`else
        chk("midrst req1 grant c", 512'(req_grant), 512'(4'b0010));
`endif

`ifdef CCIP_C0_ARB_CREDIT_EN
        // Credit limit of 2 on a lone requester.
        do_reset();
        req_valid = 4'b0001;
        #1;
        chk("cred grant 1", 512'(req_grant), 512'(4'b0001));
        tick(); #1;
        chk("cred grant 2", 512'(req_grant), 512'(4'b0001));
        tick(); #1;
        chk("cred blocked", 512'(req_grant), 512'(4'b0000));
        tick();
        rx_c0_rdvalid = 1'b1;
        rx_c0_mdata   = 16'h0000;
        #1;
        chk("cred blocked during rsp", 512'(req_grant), 512'(4'b0000));
        tick(); #1;
        chk("cred grant with rsp", 512'(req_grant), 512'(4'b0001));
        tick();
        rx_c0_rdvalid = 1'b0;
        #1;
        chk("cred grant after cancel", 512'(req_grant), 512'(4'b0001));
        tick(); #1;
        chk("cred blocked again", 512'(req_grant), 512'(4'b0000));
`endif

        do_reset();
        run_random(400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
